mdr_unit: RTL and testbench
===========================

MDR_UNIT -- requirements
Module: mdr_unit

Interface
REQ-001 Parameter WORD_LENGTH, default 16: operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 multiply, 01 divide, 10 square root, 11 invalid; sampled with start.
REQ-006 load  input  1  operand strobe; sampled only in X or Y.
REQ-007 data_in  input  WORD_LENGTH  operand value captured on load.
REQ-008 flagx  output  1  high while in X (awaiting first operand).
REQ-009 flagy  output  1  high while in Y (awaiting second operand).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 error  output  1  divide-by-zero, negative root or invalid op; valid with ready.
REQ-013 result  output  2*WORD_LENGTH  product, quotient or root.
REQ-014 remainder  output  WORD_LENGTH  division or root remainder; zero for multiply.

Function
REQ-015 States SHALL be IDLE, X, Y, CALC, DONE.
REQ-016 IDLE -> X on start with op != 11; IDLE -> DONE on start with op = 11; otherwise stay in IDLE.
REQ-017 op SHALL be registered at start acceptance; later op changes SHALL have no effect.
REQ-018 X -> Y on load for op 00/01; X -> CALC on load for op 10; no load: stay in X.
REQ-019 Y -> CALC on load; no load: stay in Y.
REQ-020 CALC SHALL last exactly WORD_LENGTH cycles for multiply and divide, and WORD_LENGTH/2 cycles for square root; then -> DONE.
REQ-021 Divisor = 0 or negative root operand SHALL bypass CALC: the final load goes directly to DONE.
REQ-022 DONE SHALL assert ready for one cycle and then -> IDLE.
REQ-023 ready SHALL rise N+1 edges after the edge sampling the final load, with N = CALC length, or 1 edge after for the bypass of REQ-021.
REQ-024 Multiply: shift-add on magnitudes; result is the full 2*WORD_LENGTH signed product.
REQ-025 Divide: restoring division on magnitudes; quotient truncates toward zero and is sign-extended into result; remainder takes the sign of the dividend.
REQ-026 Square root: non-restoring on magnitude; result = floor(sqrt(X)) zero-extended; remainder = X - root^2.
REQ-027 Error cases SHALL give result = 0, remainder = 0, error = 1.
REQ-028 result, remainder and error SHALL update only on entry to DONE and hold until the next accepted start clears them to 0.
REQ-029 start outside IDLE and load outside X/Y SHALL be ignored.
REQ-030 If start and load are high in the same IDLE cycle, only start SHALL take effect.

Reset
REQ-031 reset SHALL force IDLE and clear all outputs, operand registers and iteration counters to 0 on the next edge, including mid-CALC.
REQ-032 reset SHALL take priority over start and load on the same edge.

Configuration
REQ-033 With MDR_SIGNED_EN defined, operands SHALL be two's complement per REQ-024 to REQ-026.
REQ-034 Without MDR_SIGNED_EN, operands SHALL be unsigned, negative-root errors SHALL not exist, and quotient and remainder SHALL be zero-extended.

Verification (WORD_LENGTH=16, MDR_SIGNED_EN defined)
REQ-035 Multiply: X=0xFFF9 (-7), Y=12 -> result=0xFFFFFFAC, remainder=0, error=0; ready exactly 17 edges after the Y load.
REQ-036 Divide: X=100, Y=0xFFF9 (-7) -> result=0xFFFFFFF2 (-14), remainder=2, error=0.
REQ-037 Square root: X=1000 -> result=31, remainder=39; flagy never asserted; ready 9 edges after the X load.
REQ-038 Divide by zero: X=5, Y=0 -> ready 1 edge after the Y load, error=1, result=0; op=11 start -> DONE next edge with error=1.
REQ-039 Reset at CALC cycle 5 of a multiply -> IDLE, all outputs 0 next edge; a start pulsed during CALC is ignored and result is unchanged.

Source files
------------

// File: rtl/mdr_unit.sv
// -----------------------------------------------------------------------------
// mdr_unit -- sequential multiply / divide / square-root unit
//
// A start in IDLE latches the operation. The unit then collects one or two
// operands through load strobes, iterates one bit (multiply, divide) or one
// root digit (square root) per cycle, and reports completion with a one-cycle
// ready pulse. result / remainder / error are loaded on entry to DONE and hold
// until the next accepted start clears them.
//
// Configuration macro: MDR_SIGNED_EN
//   defined   : operands are two's complement; work is done on magnitudes and
//               signs are re-applied at the end; a negative root operand is an
//               error.
//   undefined : operands are unsigned; quotient/remainder are zero-extended.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request a new operation (IDLE only)
//   op[1:0]    in   00 mul, 01 div, 10 sqrt, 11 invalid
//   load       in   operand strobe (X or Y only)
//   data_in    in   operand value
//   flagx      out  awaiting first operand
//   flagy      out  awaiting second operand
//   busy       out  not in IDLE
//   ready      out  one-cycle completion pulse
//   error      out  divide-by-zero, negative root or invalid op
//   result     out  product / quotient / root (2*WORD_LENGTH)
//   remainder  out  division or root remainder
// -----------------------------------------------------------------------------
module mdr_unit #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic                       load,
    input  logic [WORD_LENGTH-1:0]     data_in,
    output logic                       flagx,
    output logic                       flagy,
    output logic                       busy,
    output logic                       ready,
    output logic                       error,
    output logic [2*WORD_LENGTH-1:0]   result,
    output logic [WORD_LENGTH-1:0]     remainder
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W) + 1;

`ifdef MDR_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    // Value of the iteration counter on the final CALC cycle.
    localparam logic [CW-1:0] LAST_MD = CW'(W - 1);
    localparam logic [CW-1:0] LAST_SQ = CW'(W / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_X    = 3'd1,
        S_Y    = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Operand sign (always 0 in the unsigned build).
    function automatic logic is_neg(input logic [W-1:0] v);
        return SIGNED_EN & v[W-1];
    endfunction

    // Operand magnitude; the most negative value maps to 2^(W-1) unsigned.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return is_neg(v) ? -v : v;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [W:0]          work_q, work_d;    // mul high half / div partial remainder / signed sqrt remainder
    logic [W-1:0]        sh_q, sh_d;        // mul low half / dividend->quotient / radicand
    logic [W-1:0]        opb_q, opb_d;      // multiplicand / divisor / partial root
    logic                sx_q, sx_d;        // sign of X (remainder sign for divide)
    logic                neg_res_q, neg_res_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*W-1:0]      result_q, result_d;
    logic [W-1:0]        remainder_q, remainder_d;
    logic                error_q, error_d;
    logic                flagx_q, flagy_q, busy_q, ready_q;

    // Multiply step: add multiplicand when the multiplier LSB is set, then shift right.
    logic [W:0]          mul_sum_s;
    logic [2*W-1:0]      mul_prod_s;
    assign mul_sum_s  = {1'b0, work_q[W-1:0]} + (sh_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    assign mul_prod_s = {mul_sum_s, sh_q[W-1:1]};

    // Restoring divide step: shift in next dividend bit, subtract if it fits.
    logic [W:0]          div_sh_s;
    logic                div_ge_s;
    logic [W-1:0]        div_rem_s;
    logic [W-1:0]        div_quo_s;
    assign div_sh_s  = {work_q[W-1:0], sh_q[W-1]};
    assign div_ge_s  = (div_sh_s >= {1'b0, opb_q});
    assign div_rem_s = div_ge_s ? (div_sh_s[W-1:0] - opb_q) : div_sh_s[W-1:0];
    assign div_quo_s = {sh_q[W-2:0], div_ge_s};

    // Non-restoring root step: bring in two radicand bits, then subtract
    // 4Q+1 (remainder >= 0) or add 4Q+3 (remainder < 0); the new root bit is
    // the inverted sign. A negative final remainder is corrected by 2Q+1.
    logic [W:0]          sq_sh_s;
    logic [W:0]          sq_r_s;
    logic [W-1:0]        sq_q_s;
    logic [W-1:0]        sq_fix_s;
    assign sq_sh_s  = {work_q[W-2:0], sh_q[W-1:W-2]};
    assign sq_r_s   = work_q[W] ? (sq_sh_s + {opb_q[W-2:0], 2'b11})
                                : (sq_sh_s - {opb_q[W-2:0], 2'b01});
    assign sq_q_s   = {opb_q[W-2:0], ~sq_r_s[W]};
    assign sq_fix_s = sq_r_s[W] ? (sq_r_s[W-1:0] + {sq_q_s[W-2:0], 1'b1}) : sq_r_s[W-1:0];

    // Next-state, operand capture, iteration and result loading.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        sh_d        = sh_q;
        opb_d       = opb_q;
        sx_d        = sx_q;
        neg_res_d   = neg_res_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d        = op;
                    work_d      = '0;
                    sh_d        = '0;
                    opb_d       = '0;
                    sx_d        = 1'b0;
                    neg_res_d   = 1'b0;
                    cnt_d       = '0;
                    result_d    = '0;
                    remainder_d = '0;
                    if (op == OP_INV) begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_X;
                        error_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_X: begin
                if (load) begin
                    sx_d   = is_neg(data_in);
                    sh_d   = mag(data_in);
                    work_d = '0;
                    cnt_d  = '0;
                    if (op_q == OP_SQRT) begin
                        if (is_neg(data_in)) begin
                            state_d     = S_DONE;
                            error_d     = 1'b1;
                            result_d    = '0;
                            remainder_d = '0;
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        state_d = S_Y;
                    end
                end else begin
                    state_d = S_X;
                end
            end

            S_Y: begin
                if (load) begin
                    opb_d     = mag(data_in);
                    neg_res_d = sx_q ^ is_neg(data_in);
                    if ((op_q == OP_DIV) && (data_in == '0)) begin
                        state_d     = S_DONE;
                        error_d     = 1'b1;
                        result_d    = '0;
                        remainder_d = '0;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_Y;
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                case (op_q)
                    OP_MUL: begin
                        work_d = {1'b0, mul_sum_s[W:1]};
                        sh_d   = {mul_sum_s[0], sh_q[W-1:1]};
                    end
                    OP_DIV: begin
                        work_d = {1'b0, div_rem_s};
                        sh_d   = div_quo_s;
                    end
                    OP_SQRT: begin
                        work_d = sq_r_s;
                        sh_d   = {sh_q[W-3:0], 2'b00};
                        opb_d  = sq_q_s;
                    end
                    default: begin
                        work_d = work_q;
                    end
                endcase

                if (cnt_q == ((op_q == OP_SQRT) ? LAST_SQ : LAST_MD)) begin
                    state_d = S_DONE;
                    error_d = 1'b0;
                    case (op_q)
                        OP_MUL: begin
                            result_d    = neg_res_q ? -mul_prod_s : mul_prod_s;
                            remainder_d = '0;
                        end
                        OP_DIV: begin
                            // Negate at full width so -2^(W-1) / -1 stays positive.
                            result_d    = neg_res_q ? -{{W{1'b0}}, div_quo_s} : {{W{1'b0}}, div_quo_s};
                            remainder_d = sx_q ? -div_rem_s : div_rem_s;
                        end
                        OP_SQRT: begin
                            result_d    = {{W{1'b0}}, sq_q_s};
                            remainder_d = sq_fix_s;
                        end
                        default: begin
                            result_d    = '0;
                            remainder_d = '0;
                            error_d     = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_CALC;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            work_q      <= '0;
            sh_q        <= '0;
            opb_q       <= '0;
            sx_q        <= 1'b0;
            neg_res_q   <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            error_q     <= 1'b0;
            flagx_q     <= 1'b0;
            flagy_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            sh_q        <= sh_d;
            opb_q       <= opb_d;
            sx_q        <= sx_d;
            neg_res_q   <= neg_res_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            error_q     <= error_d;
            flagx_q     <= (state_d == S_X);
            flagy_q     <= (state_d == S_Y);
            busy_q      <= (state_d != S_IDLE);
            // Pulse follows the DONE cycle, one edge after DONE is entered.
            ready_q     <= (state_q == S_DONE);
        end
    end

    assign flagx     = flagx_q;
    assign flagy     = flagy_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign result    = result_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_mdr_unit.sv
// -----------------------------------------------------------------------------
// tb_mdr_unit -- self-checking bench for mdr_unit (WORD_LENGTH = 16)
//
// Expected results come from integer arithmetic on the operand values
// (signed or unsigned depending on MDR_SIGNED_EN); latencies from the
// operation's iteration count. Directed vectors first, then random ones,
// then reset behaviour.
// -----------------------------------------------------------------------------
module tb_mdr_unit;

    localparam int WL = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      op_in;
    logic            load;
    logic [WL-1:0]   data_in;
    logic            flagx, flagy, busy, ready, error;
    logic [2*WL-1:0] result;
    logic [WL-1:0]   remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdr_unit #(.WORD_LENGTH(WL)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op_in),
        .load      (load),
        .data_in   (data_in),
        .flagx     (flagx),
        .flagy     (flagy),
        .busy      (busy),
        .ready     (ready),
        .error     (error),
        .result    (result),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [1:0] op, input logic [WL-1:0] x, input logic [WL-1:0] y,
                         output logic e_err, output logic [2*WL-1:0] e_res,
                         output logic [WL-1:0] e_rem, output int e_lat);
        longint xi, yi, p, q, r;
`ifdef MDR_SIGNED_EN
        xi = longint'($signed(x));
        yi = longint'($signed(y));
`else
        xi = longint'(x);
        yi = longint'(y);
`endif
        e_err = 1'b0;
        e_res = '0;
        e_rem = '0;
        e_lat = 1;
        case (op)
            2'b00: begin
                p = xi * yi;
                e_res = p[2*WL-1:0];
                e_lat = WL + 1;
            end
            2'b01: begin
                if (yi == 0) begin
                    e_err = 1'b1;
                end else begin
                    q = xi / yi;
                    r = xi % yi;
                    e_res = q[2*WL-1:0];
                    e_rem = r[WL-1:0];
                    e_lat = WL + 1;
                end
            end
            2'b10: begin
                if (xi < 0) begin
                    e_err = 1'b1;
                end else begin
                    r = 0;
                    while ((r + 1) * (r + 1) <= xi) r++;
                    p = xi - r * r;
                    e_res = r[2*WL-1:0];
                    e_rem = p[WL-1:0];
                    e_lat = WL / 2 + 1;
                end
            end
            default: begin
                e_err = 1'b1;
            end
        endcase
    endtask

    // Count edges until ready; optionally pulse a stray start in the first cycle.
    task automatic wait_ready(input string tag, input int exp_lat, input bit poke);
        int k = 0;
        while (ready !== 1'b1 && k < 64) begin
            start = poke && (k < 1);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk({tag, "/latency"}, 64'(k), 64'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [WL-1:0] x, input logic [WL-1:0] y);
        logic            e_err;
        logic [2*WL-1:0] e_res;
        logic [WL-1:0]   e_rem;
        int              e_lat;
        model(op, x, y, e_err, e_res, e_rem, e_lat);

        // start together with a load: only start may act
        @(negedge clk);
        start = 1'b1; op_in = op; load = 1'b1; data_in = x ^ 16'h5A5A;
        @(posedge clk); #1;
        start = 1'b0; load = 1'b0;
        op_in = op ^ 2'b01;
        chk({tag, "/clr_result"}, 64'(result), 64'd0);
        chk({tag, "/busy_start"}, 64'(busy), 64'd1);

        if (op == 2'b11) begin
            chk({tag, "/inv_err"}, 64'(error), 64'd1);
            wait_ready(tag, e_lat, 1'b1);
        end else begin
            chk({tag, "/flagx"}, 64'(flagx), 64'd1);
            chk({tag, "/clr_error"}, 64'(error), 64'd0);
            start = 1'b1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(negedge clk);
            start = 1'b0; load = 1'b1; data_in = x;
            @(posedge clk); #1;
            load = 1'b0;
            if (op == 2'b10) begin
                chk({tag, "/flagy_sqrt"}, 64'(flagy), 64'd0);
            end else begin
                chk({tag, "/flagy"}, 64'(flagy), 64'd1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(negedge clk);
                load = 1'b1; data_in = y;
                @(posedge clk); #1;
                load = 1'b0;
            end
            chk({tag, "/flags_off"}, 64'({flagx, flagy}), 64'd0);
            chk({tag, "/no_early_ready"}, 64'(ready), 64'd0);
            wait_ready(tag, e_lat, 1'b1);
        end

        chk({tag, "/error"}, 64'(error), 64'(e_err));
        chk({tag, "/result"}, 64'(result), 64'(e_res));
        chk({tag, "/remainder"}, 64'(remainder), 64'(e_rem));
        @(posedge clk); #1;
        chk({tag, "/ready_pulse"}, 64'({ready, busy}), 64'd0);
        chk({tag, "/hold"}, 64'(result), 64'(e_res));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load = 1'b0; op_in = 2'b00; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset/status", 64'({flagx, flagy, busy, ready, error}), 64'd0);
        chk("reset/data", 64'({result, remainder}), 64'd0);

        // directed vectors
        run_op("mul_neg7x12", 2'b00, 16'hFFF9, 16'd12);
        run_op("div_100_neg7", 2'b01, 16'd100, 16'hFFF9);
        run_op("sqrt_1000", 2'b10, 16'd1000, 16'd0);
        run_op("div_by_zero", 2'b01, 16'd5, 16'd0);
        run_op("invalid_op", 2'b11, 16'd0, 16'd0);
        run_op("mul_min_min", 2'b00, 16'h8000, 16'h8000);
        run_op("div_min_neg1", 2'b01, 16'h8000, 16'hFFFF);
        run_op("div_neg_rem", 2'b01, 16'hFF9C, 16'd7);
        run_op("sqrt_max", 2'b10, 16'hFFFF, 16'd0);
        run_op("sqrt_zero", 2'b10, 16'd0, 16'd0);
        run_op("mul_zero", 2'b00, 16'd0, 16'h1234);

        // random vectors
        for (int i = 0; i < 40; i++) begin
            logic [1:0]    rop;
            logic [WL-1:0] rx, ry;
            rop = 2'($urandom_range(0, 3));
            rx  = 16'($urandom);
            ry  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, rx, ry);
        end

        // reset clears a held result
        run_op("pre_reset", 2'b00, 16'd300, 16'd7);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("idle_reset/result", 64'(result), 64'd0);

        // reset in the 5th CALC cycle, with start and load on the same edge
        @(negedge clk); start = 1'b1; op_in = 2'b00;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); load = 1'b1; data_in = 16'd3;
        @(posedge clk); #1; load = 1'b0;
        @(negedge clk); load = 1'b1; data_in = 16'd5;
        @(posedge clk); #1; load = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); reset = 1'b1; start = 1'b1; load = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; load = 1'b0;
        chk("calc_reset/status", 64'({flagx, flagy, busy, ready, error}), 64'd0);
        chk("calc_reset/data", 64'({result, remainder}), 64'd0);
        repeat (WL + 4) @(posedge clk);
        #1;
        chk("calc_reset/stays_idle", 64'({busy, ready}), 64'd0);

        // unit still works after the abort
        run_op("post_reset", 2'b01, 16'd1234, 16'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
